// File: rtl/phase_sequencer.sv
// Purpose : steps an instruction through phases 1..LAST_PHASE, parks in phase 0 when idle/stopped/stepped/halted.
// Latency : a start edge sampled in PARK gives phase 1 after that clock; phase LAST_PHASE is followed directly by 1 (no bubble).
// Backpr. : none; stop requests are deferred to the instruction boundary, start edges outside PARK are ignored.
//
// Ports:
//   clk         - system clock, all state updates on the rising edge
//   rst         - synchronous active-low reset
//   start, stop - debounced panel button levels (rising edge detected here)
//   step_mode   - 1 = park after every instruction
//   hlt         - halt request from the control decoder, honoured only in phase LAST_PHASE
//   phase       - current phase, 0 = parked
//   running     - phase != 0 (combinational)
//   halted      - sticky, set when an HLT instruction completes
//   retire      - one-cycle pulse in the cycle after a phase-LAST_PHASE cycle
//   instr_count - retired-instruction counter, wrapping
module phase_sequencer #(
    parameter int unsigned LAST_PHASE = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step_mode,
    input  logic             hlt,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] PARK = 3'd0;
    localparam logic [2:0] LAST = 3'(LAST_PHASE);

    logic [2:0]       phase_q, phase_d;
    logic             halted_q, halted_d;
    logic             stop_pend_q, stop_pend_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    // Previous button levels; their next value is simply the raw input.
    logic             start_q;
    logic             stop_q;

    logic             start_rise;
    logic             stop_rise;

    assign start_rise = start & ~start_q;
    assign stop_rise  = stop  & ~stop_q;

    always_comb begin
        phase_d       = phase_q;
        halted_d      = halted_q;
        stop_pend_d   = stop_pend_q;
        retire_d      = 1'b0;
        instr_count_d = instr_count_q;

        if (phase_q == PARK) begin
            // A stop edge coinciding with the start edge is dropped: the
            // start path clears any pending stop.
            if (start_rise) begin
                phase_d     = 3'd1;
                halted_d    = 1'b0;
                stop_pend_d = 1'b0;
            end
        end else if (phase_q == LAST) begin
            // Instruction boundary: the instruction always retires here.
            instr_count_d = instr_count_q + CNT_W'(1);
            retire_d      = 1'b1;
            if (hlt) begin
                phase_d     = PARK;
                halted_d    = 1'b1;
                stop_pend_d = 1'b0;
            end else if (stop_pend_q || stop_rise) begin
                phase_d     = PARK;
                stop_pend_d = 1'b0;
            end else if (step_mode) begin
                phase_d     = PARK;
            end else begin
                phase_d     = 3'd1;
            end
        end else begin
            // Mid-instruction: never abort, only remember a stop request.
            phase_d = phase_q + 3'd1;
            if (stop_rise) begin
                stop_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q       <= PARK;
            halted_q      <= 1'b0;
            stop_pend_q   <= 1'b0;
            retire_q      <= 1'b0;
            instr_count_q <= '0;
            // Treat the buttons as already pressed so a level held through
            // reset does not look like a fresh edge.
            start_q       <= 1'b1;
            stop_q        <= 1'b1;
        end else begin
            phase_q       <= phase_d;
            halted_q      <= halted_d;
            stop_pend_q   <= stop_pend_d;
            retire_q      <= retire_d;
            instr_count_q <= instr_count_d;
            start_q       <= start;
            stop_q        <= stop;
        end
    end

    assign phase       = phase_q;
    assign running     = (phase_q != PARK);
    assign halted      = halted_q;
    assign retire      = retire_q;
    assign instr_count = instr_count_q;

endmodule
